// File: rtl/image_buffer_writer.sv
// Producer side of the ping-pong image BRAM: writes one pixel per word into alternating
// buffers, starts the reader per completed image and frees buffers on the reader's done.
module image_buffer_writer #(
   parameter int unsigned NUM_PIXELS = 784,
   parameter logic [31:0] BASE_ADDR1 = 32'hB000_0000,
   parameter logic [31:0] BASE_ADDR2 = 32'hB000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  pixel_i,
   input  logic        pixel_valid_i,
   output logic        pixel_ready_o,
   output logic        bram_we,
   output logic [31:0] bram_address,
   output logic [31:0] bram_wdata,
   output logic        start_o,
   input  logic        image_done_i,
   output logic        err_o
);

   typedef enum logic {FILL, STALL} state_t;

   localparam logic [9:0] LAST_PIXEL = 10'(NUM_PIXELS - 1);

   state_t     state, state_next;
   logic [1:0] full, full_next;
   logic       wr_sel, wr_sel_next;
   logic       rd_sel, rd_sel_next;
   logic       reader_busy, reader_busy_next;
   logic [9:0] pix_cnt, pix_cnt_next;
   logic       start_next, err_next;
   logic       accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FILL;
         full        <= '0;
         wr_sel      <= 1'b0;
         rd_sel      <= 1'b0;
         reader_busy <= 1'b0;
         pix_cnt     <= '0;
         start_o     <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state       <= state_next;
         full        <= full_next;
         wr_sel      <= wr_sel_next;
         rd_sel      <= rd_sel_next;
         reader_busy <= reader_busy_next;
         pix_cnt     <= pix_cnt_next;
         start_o     <= start_next;
         err_o       <= err_next;
      end
   end

   // Freeing (rd_sel) and filling (wr_sel) the same edge never collide: the writer only
   // completes into a buffer the reader is not holding.
   always_comb begin
      full_next        = full;
      wr_sel_next      = wr_sel;
      rd_sel_next      = rd_sel;
      reader_busy_next = reader_busy;
      pix_cnt_next     = pix_cnt;
      start_next       = 1'b0;
      err_next         = err_o;

      if (accept) begin
         if (pix_cnt == LAST_PIXEL) begin
            pix_cnt_next      = '0;
            full_next[wr_sel] = 1'b1;
            wr_sel_next       = ~wr_sel;
         end else begin
            pix_cnt_next = pix_cnt + 10'd1;
         end
      end

      if (image_done_i) begin
         if (reader_busy) begin
            full_next[rd_sel] = 1'b0;
            rd_sel_next       = ~rd_sel;
            reader_busy_next  = 1'b0;
         end else begin
            err_next = 1'b1;
         end
      end

      if (full[rd_sel] && !reader_busy && !start_o) begin
         start_next       = 1'b1;
         reader_busy_next = 1'b1;
      end

      state_next = full_next[wr_sel_next] ? STALL : FILL;
   end

   always_comb begin
      pixel_ready_o = (state == FILL);
      accept        = pixel_valid_i && (state == FILL);
      bram_we       = 1'b0;
      bram_address  = '0;
      bram_wdata    = '0;
      if (accept) begin
         bram_we      = 1'b1;
         bram_address = (wr_sel ? BASE_ADDR2 : BASE_ADDR1) + {20'b0, pix_cnt, 2'b00};
         bram_wdata   = {24'b0, pixel_i};
      end
   end

endmodule

// File: tb/tb_image_buffer_writer.sv
// Self-checking bench for image_buffer_writer: a cycle model predicts ready/start/err and
// a queue of expected BRAM writes is matched against the DUT write port.
module tb_image_buffer_writer;

   localparam logic [31:0] B1 = 32'hB000_0000;
   localparam logic [31:0] B2 = 32'hB000_1000;
   localparam int unsigned NPIX = 784;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  pixel = '0;
   logic        pixel_valid = 1'b0;
   logic        pixel_ready;
   logic        bram_we;
   logic [31:0] bram_address;
   logic [31:0] bram_wdata;
   logic        start;
   logic        image_done = 1'b0;
   logic        err;

   image_buffer_writer #(
      .NUM_PIXELS(NPIX),
      .BASE_ADDR1(B1),
      .BASE_ADDR2(B2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pixel_i      (pixel),
      .pixel_valid_i(pixel_valid),
      .pixel_ready_o(pixel_ready),
      .bram_we      (bram_we),
      .bram_address (bram_address),
      .bram_wdata   (bram_wdata),
      .start_o      (start),
      .image_done_i (image_done),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned n_starts = 0;
   logic [63:0] exp_q[$];
   logic [31:0] first_addr, last_addr;
   logic        want_first;

   // reference model state (register values after the latest edge)
   logic [1:0] m_full;
   logic       m_wr, m_rd, m_busy, m_start, m_err;
   logic [9:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_full = '0; m_wr = 1'b0; m_rd = 1'b0; m_busy = 1'b0;
      m_start = 1'b0; m_err = 1'b0; m_cnt = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      pixel_valid = 1'b0; image_done = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_ready", {31'b0, pixel_ready}, 32'd1);
      check("rst_we",    {31'b0, bram_we}, 32'd0);
      check("rst_start", {31'b0, start}, 32'd0);
      check("rst_err",   {31'b0, err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      exp_q.delete();
      n_starts = 0;
      @(posedge clk);
      #1;
   endtask

   // One clock: drive at posedge+1, check at negedge, advance model after the next posedge.
   task automatic cycle(input logic v, input logic [7:0] p, input logic d, output logic acc);
      logic [63:0] e;
      logic        er, st_n, busy_n, rd_n, wr_n, err_n;
      logic [1:0]  full_n;
      logic [9:0]  cnt_n;
      pixel_valid = v; pixel = p; image_done = d;
      er  = ~m_full[m_wr];
      acc = v & er;
      if (acc) exp_q.push_back({(m_wr ? B2 : B1) + {20'b0, m_cnt, 2'b00}, 24'b0, p});
      @(negedge clk);
      check("ready", {31'b0, pixel_ready}, {31'b0, er});
      check("we",    {31'b0, bram_we}, {31'b0, acc});
      check("start", {31'b0, start}, {31'b0, m_start});
      check("err",   {31'b0, err}, {31'b0, m_err});
      if (start) n_starts++;
      if (bram_we) begin
         if (exp_q.size() == 0) begin
            check("spurious_we", {31'b0, bram_we}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("addr",  bram_address, e[63:32]);
            check("wdata", bram_wdata, e[31:0]);
         end
         last_addr = bram_address;
         if (want_first) begin
            first_addr = bram_address;
            want_first = 1'b0;
         end
      end else begin
         check("idle_addr",  bram_address, 32'd0);
         check("idle_wdata", bram_wdata, 32'd0);
      end
      @(posedge clk);
      #1;
      full_n = m_full; wr_n = m_wr; rd_n = m_rd; busy_n = m_busy; cnt_n = m_cnt;
      err_n = m_err; st_n = 1'b0;
      if (acc) begin
         if (m_cnt == 10'(NPIX - 1)) begin
            cnt_n = '0; full_n[m_wr] = 1'b1; wr_n = ~m_wr;
         end else begin
            cnt_n = m_cnt + 10'd1;
         end
      end
      if (d) begin
         if (m_busy) begin
            full_n[m_rd] = 1'b0; rd_n = ~m_rd; busy_n = 1'b0;
         end else begin
            err_n = 1'b1;
         end
      end
      if (m_full[m_rd] && !m_busy && !m_start) begin
         st_n = 1'b1; busy_n = 1'b1;
      end
      m_full = full_n; m_wr = wr_n; m_rd = rd_n; m_busy = busy_n;
      m_cnt = cnt_n; m_err = err_n; m_start = st_n;
   endtask

   task automatic idle(input int unsigned n);
      logic acc;
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, acc);
   endtask

   task automatic done_pulse();
      logic acc;
      cycle(1'b0, 8'h00, 1'b1, acc);
   endtask

   task automatic send_image(input int unsigned n, input int unsigned gap_pct,
                             input logic done_last, input int unsigned budget,
                             output int unsigned sent);
      int unsigned i, cyc;
      logic v, acc;
      i = 0; cyc = 0;
      want_first = 1'b1;
      while (i < n && cyc < budget) begin
         v = ($urandom_range(99) >= gap_pct);
         cycle(v, i[7:0], done_last && v && (i == n - 1), acc);
         if (acc) i++;
         cyc++;
      end
      sent = i;
   endtask

   initial begin
      int unsigned sent;
      model_clear();
      first_addr = '0; last_addr = '0; want_first = 1'b0;
      repeat (2) @(posedge clk);

      // 1: one full image back-to-back
      do_reset();
      send_image(NPIX, 0, 1'b0, 2000, sent);
      check("t1_sent", sent, NPIX);
      check("t1_first_addr", first_addr, 32'hB000_0000);
      check("t1_last_addr", last_addr, 32'hB000_0C3C);
      idle(3);
      check("t1_starts", n_starts, 32'd1);

      // 2: second image fills buffer 1, third blocked
      send_image(NPIX, 0, 1'b0, 2000, sent);
      check("t2_sent", sent, NPIX);
      check("t2_first_addr", first_addr, 32'hB000_1000);
      check("t2_last_addr", last_addr, 32'hB000_1C3C);
      send_image(NPIX, 0, 1'b0, 40, sent);
      check("t2_blocked", sent, 32'd0);
      check("t2_ready_low", {31'b0, pixel_ready}, 32'd0);
      check("t2_starts", n_starts, 32'd1);

      // 3: free buffer 0, refill it, then free buffer 1
      done_pulse();
      send_image(NPIX, 0, 1'b0, 2000, sent);
      check("t3_sent", sent, NPIX);
      check("t3_first_addr", first_addr, 32'hB000_0000);
      check("t3_starts_a", n_starts, 32'd2);
      done_pulse();
      idle(4);
      check("t3_starts_b", n_starts, 32'd3);
      check("t3_ready", {31'b0, pixel_ready}, 32'd1);

      // 4: done coincides with last pixel of buffer 1
      do_reset();
      send_image(NPIX, 0, 1'b0, 2000, sent);
      idle(3);
      send_image(NPIX, 0, 1'b1, 2000, sent);
      check("t4_sent", sent, NPIX);
      send_image(10, 0, 1'b0, 20, sent);
      check("t4_nostall", sent, 32'd10);
      check("t4_first_addr", first_addr, 32'hB000_0000);
      check("t4_starts", n_starts, 32'd2);

      // 5: spurious done sets sticky error; gapped stream stays contiguous
      do_reset();
      done_pulse();
      check("t5_err_set", {31'b0, err}, 32'd1);
      send_image(NPIX, 30, 1'b0, 6000, sent);
      check("t5_sent", sent, NPIX);
      check("t5_last_addr", last_addr, 32'hB000_0C3C);
      idle(3);
      check("t5_starts", n_starts, 32'd1);
      check("t5_err_sticky", {31'b0, err}, 32'd1);

      // 6: reset mid-image discards it
      do_reset();
      send_image(300, 0, 1'b0, 400, sent);
      do_reset();
      send_image(1, 0, 1'b0, 5, sent);
      check("t6_first_addr", first_addr, 32'hB000_0000);
      idle(5);
      check("t6_starts", n_starts, 32'd0);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
